// File: rtl/collision_scan_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_pkg
// Description : Shared types and default geometry for the collision scan
//               engine (move opcodes, FSM states, board/piece dimensions).
// Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_PIECE_N = 4;

    // Two-bit opcode space is fully populated, so no illegal op exists.
    typedef enum logic [1:0] {
        OP_DOWN   = 2'd0,
        OP_LEFT   = 2'd1,
        OP_RIGHT  = 2'd2,
        OP_ROTATE = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/collision_scan_engine_row_collide.sv
`default_nettype none
// ============================================================================
// Module      : row_collide
// Description : Combinational test of one piece-pattern row against one board
//               row at a signed column offset. Cells left/right of the board or
//               below the floor count as hits and never index the board.
// Revision    : 1.0 - initial release
// ============================================================================
module row_collide #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int PIECE_N = 4,
    parameter int XW      = 4,
    parameter int RW      = 7
) (
    input  logic [PIECE_N-1:0]   row_bits,
    input  logic signed [XW:0]   tx,
    input  logic signed [RW-1:0] row_idx,
    input  logic [BOARD_W-1:0]   board_row,
    output logic                 hit
);

    // Any set pattern cell that lands off-board or on an occupied cell hits.
    always_comb begin
        int col;
        col = 0;
        hit = 1'b0;
        for (int c = 0; c < PIECE_N; c++) begin
            if (row_bits[c]) begin
                col = int'(tx) + c;
                if (col < 0 || col >= BOARD_W ||
                    int'(row_idx) < 0 || int'(row_idx) >= BOARD_H) begin
                    hit = 1'b1;
                end else begin
                    for (int b = 0; b < BOARD_W; b++) begin
                        if (col == b && board_row[b]) begin
                            hit = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/collision_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : collision_scan_engine
// Description : Sequential collision checker. Accepts one move request, scans
//               the candidate placement one pattern row per cycle against the
//               board, then holds collide/accept and the resulting anchor until
//               the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scan_engine
    import collision_pkg::*;
#(
    parameter int   BOARD_W = DEF_BOARD_W,
    parameter int   BOARD_H = DEF_BOARD_H,
    parameter int   PIECE_N = DEF_PIECE_N,
    localparam int  XW      = $clog2(BOARD_W),
    localparam int  YW      = $clog2(BOARD_H)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [XW-1:0]                req_x,
    input  logic [YW-1:0]                req_y,
    input  logic [PIECE_N*PIECE_N-1:0]   req_pattern,
    input  logic [BOARD_H*BOARD_W-1:0]   board,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_collide,
    output logic [XW-1:0]                resp_x,
    output logic [YW-1:0]                resp_y
);

    localparam int KW = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
    // Row index must hold ty (up to 2^YW) plus the largest row offset, signed.
    localparam int RW = YW + 2;
    localparam logic signed [XW:0] c_one_x = (XW+1)'(1);
    localparam logic signed [YW:0] c_one_y = (YW+1)'(1);

    state_t                       state_q, state_d;
    logic [KW-1:0]                k_q, k_d;
    logic [XW-1:0]                x_q, x_d;
    logic [YW-1:0]                y_q, y_d;
    logic signed [XW:0]           tx_q, tx_d;
    logic signed [YW:0]           ty_q, ty_d;
    logic [PIECE_N*PIECE_N-1:0]   pattern_q, pattern_d;
    logic                         sticky_q, sticky_d;
    logic                         resp_valid_q, resp_valid_d;
    logic                         resp_collide_q, resp_collide_d;
    logic [XW-1:0]                resp_x_q, resp_x_d;
    logic [YW-1:0]                resp_y_q, resp_y_d;

    logic signed [XW:0]           w_tx_base;
    logic signed [YW:0]           w_ty_base;
    logic signed [RW-1:0]         w_row_idx;
    logic [PIECE_N-1:0]           w_row_bits;
    logic [BOARD_W-1:0]           w_board_row;
    logic                         w_hit;

    assign w_tx_base = {1'b0, req_x};
    assign w_ty_base = {1'b0, req_y};
    assign w_row_idx = {{(RW-YW-1){ty_q[YW]}}, ty_q} + RW'(k_q);

    // Select pattern row k and the board row it lands on; rows below the
    // floor select nothing and the row checker flags them itself.
    always_comb begin
        w_row_bits  = '0;
        w_board_row = '0;
        for (int r = 0; r < PIECE_N; r++) begin
            if (k_q == KW'(r)) begin
                w_row_bits = pattern_q[r*PIECE_N +: PIECE_N];
            end
        end
        for (int r = 0; r < BOARD_H; r++) begin
            if (int'(w_row_idx) == r) begin
                w_board_row = board[r*BOARD_W +: BOARD_W];
            end
        end
    end

    row_collide #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .PIECE_N (PIECE_N),
        .XW      (XW),
        .RW      (RW)
    ) u_row_collide (
        .row_bits  (w_row_bits),
        .tx        (tx_q),
        .row_idx   (w_row_idx),
        .board_row (w_board_row),
        .hit       (w_hit)
    );

    // Next-state logic: accept, fixed-length scan, then registered response.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        x_d            = x_q;
        y_d            = y_q;
        tx_d           = tx_q;
        ty_d           = ty_q;
        pattern_d      = pattern_q;
        sticky_d       = sticky_q;
        resp_valid_d   = resp_valid_q;
        resp_collide_d = resp_collide_q;
        resp_x_d       = resp_x_q;
        resp_y_d       = resp_y_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    x_d       = req_x;
                    y_d       = req_y;
                    pattern_d = req_pattern;
                    sticky_d  = 1'b0;
                    k_d       = '0;
                    tx_d      = w_tx_base;
                    ty_d      = w_ty_base;
                    case (op_t'(req_op))
                        OP_DOWN:   ty_d = w_ty_base + c_one_y;
                        OP_LEFT:   tx_d = w_tx_base - c_one_x;
                        OP_RIGHT:  tx_d = w_tx_base + c_one_x;
                        OP_ROTATE: tx_d = w_tx_base;
                    endcase
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // No early exit: every row is scanned so latency is fixed.
                sticky_d = sticky_q | w_hit;
                if (k_q == KW'(PIECE_N-1)) begin
                    state_d = ST_RESP;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_RESP: begin
                // First RESP cycle loads the output flops; then hold for handshake.
                if (!resp_valid_q) begin
                    resp_valid_d   = 1'b1;
                    resp_collide_d = sticky_q;
                    resp_x_d       = sticky_q ? x_q : tx_q[XW-1:0];
                    resp_y_d       = sticky_q ? y_q : ty_q[YW-1:0];
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            tx_q           <= '0;
            ty_q           <= '0;
            pattern_q      <= '0;
            sticky_q       <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_collide_q <= 1'b0;
            resp_x_q       <= '0;
            resp_y_q       <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            x_q            <= x_d;
            y_q            <= y_d;
            tx_q           <= tx_d;
            ty_q           <= ty_d;
            pattern_q      <= pattern_d;
            sticky_q       <= sticky_d;
            resp_valid_q   <= resp_valid_d;
            resp_collide_q <= resp_collide_d;
            resp_x_q       <= resp_x_d;
            resp_y_q       <= resp_y_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_collide = resp_collide_q;
    assign resp_x       = resp_x_q;
    assign resp_y       = resp_y_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scan_engine
// Description : Self-checking bench for collision_scan_engine: directed board
//               scenarios, handshake hold, mid-scan reset and random moves
//               against a cell-by-cell placement model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scan_engine;

    localparam int BW = 10;
    localparam int BH = 20;
    localparam int PN = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [3:0]           req_x;
    logic [4:0]           req_y;
    logic [PN*PN-1:0]     req_pattern;
    logic [BH*BW-1:0]     board;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_collide;
    logic [3:0]           resp_x;
    logic [4:0]           resp_y;

    bit board_m [BH][BW];
    int errors = 0;
    int checks = 0;

    collision_scan_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_pattern  (req_pattern),
        .board        (board),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_collide (resp_collide),
        .resp_x       (resp_x),
        .resp_y       (resp_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                board_m[r][c] = 1'b0;
    endtask

    task automatic drive_board();
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                board[r*BW + c] = board_m[r][c];
    endtask

    // Reference: place the pattern at the moved anchor and test every cell.
    task automatic model(input int op, input int x, input int y, input logic [PN*PN-1:0] pat,
                         output int col, output int rx, output int ry);
        int tx, ty, cx, cy;
        tx = x; ty = y;
        if (op == 0) ty = y + 1;
        if (op == 1) tx = x - 1;
        if (op == 2) tx = x + 1;
        col = 0;
        for (int k = 0; k < PN; k++)
            for (int c = 0; c < PN; c++)
                if (pat[k*PN + c]) begin
                    cx = tx + c; cy = ty + k;
                    if (cx < 0 || cx >= BW || cy >= BH) col = 1;
                    else if (board_m[cy][cx]) col = 1;
                end
        rx = col ? x : tx;
        ry = col ? y : ty;
    endtask

    // Present a request and return #1 after the accepting edge.
    task automatic send(input int op, input int x, input int y, input logic [PN*PN-1:0] pat);
        int n;
        req_op = op[1:0]; req_x = x[3:0]; req_y = y[4:0]; req_pattern = pat;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_before_accept", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run(input string tag, input int op, input int x, input int y,
                       input logic [PN*PN-1:0] pat, input int exp_col);
        int col, rx, ry, lat;
        model(op, x, y, pat, col, rx, ry);
        if (exp_col >= 0) chk({tag, "_model_sanity"}, col, exp_col);
        send(op, x, y, pat);
        wait_resp(lat);
        chk({tag, "_latency"}, lat, PN + 1);
        chk({tag, "_collide"}, int'(resp_collide), col);
        chk({tag, "_x"}, int'(resp_x), rx & 15);
        chk({tag, "_y"}, int'(resp_y), ry & 31);
        chk({tag, "_req_ready_busy"}, int'(req_ready), 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(resp_valid), 0);
        chk({tag, "_req_ready_idle"}, int'(req_ready), 1);
    endtask

    initial begin
        int col, rx, ry, lat, saw;
        logic [PN*PN-1:0] pat;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_x = '0; req_y = '0; req_pattern = '0;
        clear_board(); drive_board();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_collide", int'(resp_collide), 0);
        chk("reset_x", int'(resp_x), 0);
        chk("reset_y", int'(resp_y), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_req_ready", int'(req_ready), 1);

        // T piece down on empty board.
        run("t1_t_down", 0, 3, 0, 16'h0027, 0);
        // Vertical I at left wall, move left: no wrap.
        run("t2_i_left_wall", 1, 0, 0, 16'h1111, 1);
        // O piece against right wall, then one column in.
        run("t3_o_right_wall", 2, 8, 5, 16'h0033, 1);
        run("t3_o_right_ok", 2, 7, 5, 16'h0033, 0);
        // Full bottom row, then floor.
        for (int c = 0; c < BW; c++) board_m[19][c] = 1'b1;
        drive_board();
        run("t4_o_on_full_row", 0, 4, 17, 16'h0033, 1);
        clear_board(); drive_board();
        run("t4_o_floor", 0, 4, 18, 16'h0033, 1);
        // Rotate into an occupied cell, and empty pattern.
        board_m[1][0] = 1'b1; drive_board();
        run("t5_rotate_hit", 3, 0, 0, 16'h1111, 1);
        run("t5_empty_pattern", 3, 0, 0, 16'h0000, 0);
        clear_board(); drive_board();

        // Hold the response for five cycles.
        model(1, 5, 10, 16'h0027, col, rx, ry);
        send(1, 5, 10, 16'h0027);
        wait_resp(lat);
        chk("t6_hold_latency", lat, PN + 1);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t6_hold_valid", int'(resp_valid), 1);
            chk("t6_hold_collide", int'(resp_collide), col);
            chk("t6_hold_x", int'(resp_x), rx);
            chk("t6_hold_y", int'(resp_y), ry);
            chk("t6_hold_req_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("t6_hold_release", int'(resp_valid), 0);

        // Reset mid-scan aborts the request.
        send(0, 2, 2, 16'h0033);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst_req_ready", int'(req_ready), 1);
        chk("t6_async_rst_valid", int'(resp_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (resp_valid) saw = 1;
        end
        chk("t6_no_resp_after_rst", saw, 0);
        chk("t6_req_ready_after_rst", int'(req_ready), 1);

        // Random boards, pieces and moves.
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < BH; r++)
                for (int c = 0; c < BW; c++)
                    board_m[r][c] = ($urandom_range(0, 99) < 15);
            drive_board();
            pat = PN*PN'($urandom);
            if ($urandom_range(0, 3) == 0) pat = pat & 16'h0033;
            run("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 19)), pat, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
